nios_wallet_cpu_cpu_ocimem_arbiter: RTL and testbench

Arbitrates the single-port on-chip debug memory (OCI RAM) of the `nios_wallet_cpu` core between two requesters: the JTAG debug path, and the CPU's debug memory slave. The JTAG path is driven by the `take_action_ocimem_a`/`take_action_ocimem_b` strobes and `jdo` from the debug slave sysclk domain. The block:
- decodes JTAG commands and keeps the auto-incrementing JTAG address;
- gives JTAG strict priority;
- produces `MonDReg` for the debug slave's capture path.

---
 rtl/nios_wallet_cpu_cpu_ocimem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_nios_wallet_cpu_cpu_ocimem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_wallet_cpu_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nios_wallet_cpu_cpu_ocimem_arbiter
//  Function : Arbitrates the single-port OCI debug RAM between the JTAG
//             debug path (strict priority) and the CPU debug memory slave.
//             Decodes the JTAG ocimem strobes, keeps the auto-incrementing
//             JTAG word address and captures JTAG read data into MonDReg.
//  Options  : NIOS_WALLET_OCIMEM_STALL_CNT_EN - when defined, stall_cnt is a
//             saturating count of CPU cycles blocked by JTAG activity;
//             otherwise stall_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module nios_wallet_cpu_cpu_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_writedata,
   output logic              cpu_waitrequest,
   output logic [DATA_W-1:0] cpu_readdata,
   output logic              cpu_readdatavalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              jtag_busy,
   output logic [7:0]        stall_cnt
);

   // Arbiter states: CRDx / JRDx cover the two-cycle RAM read latency of a
   // CPU or JTAG read respectively.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CRD1 = 3'd1,
      ST_CRD2 = 3'd2,
      ST_JRD1 = 3'd3,
      ST_JRD2 = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // JTAG side
   logic [ADDR_W-1:0]   r_jaddr;
   logic [DATA_W-1:0]   r_jwdata;
   logic                r_jwr_pend;
   logic                r_jrd_pend;

   // RAM port and return-data registers
   logic [ADDR_W-1:0]   r_ram_addr;
   logic                r_ram_wren;
   logic [DATA_W-1:0]   r_ram_wdata;
   logic [DATA_W-1:0]   r_cpu_readdata;
   logic                r_cpu_readdatavalid;
   logic [DATA_W-1:0]   r_mondreg;

   // Per-cycle issue decisions from the arbiter
   logic                w_jwr_issue;
   logic                w_jrd_issue;
   logic                w_cpu_wr_issue;
   logic                w_cpu_rd_issue;
   logic                w_cpu_grant;
   logic                w_cpu_req;
   logic                w_jtag_busy;

   // jdo carries fields for other OCI functions in its outer bits
   logic                w_unused_jdo;
   assign w_unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

   assign w_cpu_req   = cpu_read | cpu_write;
   assign w_jtag_busy = r_jwr_pend | r_jrd_pend |
                        (r_state == ST_JRD1) | (r_state == ST_JRD2);
   assign w_cpu_grant = w_cpu_wr_issue | w_cpu_rd_issue;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and issue decode: JTAG write, then JTAG read, then CPU.
   // A CPU request with both read and write high is serviced as a read.
   always_comb begin
      w_state_nxt    = r_state;
      w_jwr_issue    = 1'b0;
      w_jrd_issue    = 1'b0;
      w_cpu_wr_issue = 1'b0;
      w_cpu_rd_issue = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_jwr_pend) begin
               w_jwr_issue = 1'b1;
            end else if (r_jrd_pend) begin
               w_jrd_issue = 1'b1;
               w_state_nxt = ST_JRD1;
            end else if (cpu_read) begin
               w_cpu_rd_issue = 1'b1;
               w_state_nxt    = ST_CRD1;
            end else if (cpu_write) begin
               w_cpu_wr_issue = 1'b1;
            end
         end
         ST_CRD1: w_state_nxt = ST_CRD2;
         ST_CRD2: w_state_nxt = ST_IDLE;
         ST_JRD1: w_state_nxt = ST_JRD2;
         ST_JRD2: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // JTAG command decode, pending flags and auto-incrementing address.
   // A new address load from strobe _a overrides any increment that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_jaddr    <= '0;
         r_jwdata   <= '0;
         r_jwr_pend <= 1'b0;
         r_jrd_pend <= 1'b0;
      end else begin
         if (w_jwr_issue) begin
            r_jwr_pend <= 1'b0;
         end
         if (w_jrd_issue) begin
            r_jrd_pend <= 1'b0;
         end
         if (w_jwr_issue || (r_state == ST_JRD2)) begin
            r_jaddr <= r_jaddr + ADDR_W'(1);
         end
         if (take_action_ocimem_a) begin
            r_jaddr <= jdo[26 +: ADDR_W];
            if (jdo[35]) begin
               r_jrd_pend <= 1'b1;
            end
         end else if (take_action_ocimem_b) begin
            if (jdo[35]) begin
               r_jrd_pend <= 1'b1;
            end else begin
               r_jwr_pend <= 1'b1;
               r_jwdata   <= jdo[34:3];
            end
         end
      end
   end

   // RAM port registers: address/data hold, write enable is a single pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ram_addr  <= '0;
         r_ram_wren  <= 1'b0;
         r_ram_wdata <= '0;
      end else begin
         r_ram_wren <= 1'b0;
         if (w_jwr_issue) begin
            r_ram_addr  <= r_jaddr;
            r_ram_wdata <= r_jwdata;
            r_ram_wren  <= 1'b1;
         end else if (w_jrd_issue) begin
            r_ram_addr  <= r_jaddr;
         end else if (w_cpu_wr_issue) begin
            r_ram_addr  <= cpu_address;
            r_ram_wdata <= cpu_writedata;
            r_ram_wren  <= 1'b1;
         end else if (w_cpu_rd_issue) begin
            r_ram_addr  <= cpu_address;
         end
      end
   end

   // Read-data capture for the CPU return path and the JTAG MonDReg
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_readdata      <= '0;
         r_cpu_readdatavalid <= 1'b0;
         r_mondreg           <= '0;
      end else begin
         r_cpu_readdatavalid <= (r_state == ST_CRD2);
         if (r_state == ST_CRD2) begin
            r_cpu_readdata <= ram_rdata;
         end
         if (r_state == ST_JRD2) begin
            r_mondreg <= ram_rdata;
         end
      end
   end

`ifdef NIOS_WALLET_OCIMEM_STALL_CNT_EN
   logic [7:0] r_stall_cnt;

   // Saturating count of CPU request cycles held off by JTAG activity
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= 8'd0;
      end else if (w_cpu_req && w_jtag_busy && (r_stall_cnt != 8'hFF)) begin
         r_stall_cnt <= r_stall_cnt + 8'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   logic w_unused_req;
   assign w_unused_req = w_cpu_req;
   assign stall_cnt    = 8'd0;
`endif

   assign cpu_waitrequest   = ~w_cpu_grant;
   assign cpu_readdata      = r_cpu_readdata;
   assign cpu_readdatavalid = r_cpu_readdatavalid;
   assign ram_addr          = r_ram_addr;
   assign ram_wren          = r_ram_wren;
   assign ram_wdata         = r_ram_wdata;
   assign MonDReg           = r_mondreg;
   assign jtag_busy         = w_jtag_busy;

endmodule
`default_nettype wire

// File: tb/tb_nios_wallet_cpu_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios_wallet_cpu_cpu_ocimem_arbiter
//  Function : Self-checking bench for the OCI RAM arbiter. Directed steps
//             followed by a randomized mix of CPU and JTAG accesses, checked
//             against a shadow-memory model with fixed latency rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nios_wallet_cpu_cpu_ocimem_arbiter;

   localparam int AW = 8;
`ifdef NIOS_WALLET_OCIMEM_STALL_CNT_EN
   localparam logic [7:0] STALL_EXP = 8'd1;
`else
   localparam logic [7:0] STALL_EXP = 8'd0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          take_a;
   logic          take_b;
   logic [37:0]   jdo;
   logic [AW-1:0] cpu_address;
   logic          cpu_read;
   logic          cpu_write;
   logic [31:0]   cpu_writedata;
   logic          cpu_waitrequest;
   logic [31:0]   cpu_readdata;
   logic          cpu_readdatavalid;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [31:0]   MonDReg;
   logic          jtag_busy;
   logic [7:0]    stall_cnt;

   nios_wallet_cpu_cpu_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .take_action_ocimem_a (take_a),
      .take_action_ocimem_b (take_b),
      .jdo                  (jdo),
      .cpu_address          (cpu_address),
      .cpu_read             (cpu_read),
      .cpu_write            (cpu_write),
      .cpu_writedata        (cpu_writedata),
      .cpu_waitrequest      (cpu_waitrequest),
      .cpu_readdata         (cpu_readdata),
      .cpu_readdatavalid    (cpu_readdatavalid),
      .ram_addr             (ram_addr),
      .ram_wren             (ram_wren),
      .ram_wdata            (ram_wdata),
      .ram_rdata            (ram_rdata),
      .MonDReg              (MonDReg),
      .jtag_busy            (jtag_busy),
      .stall_cnt            (stall_cnt)
   );

   always #5 clk = ~clk;

   // Single-port RAM, read data one cycle after the address
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Reference model state
   logic [31:0] shadow [0:255];
   bit          written [0:255];
   logic [7:0]  wq [$];
   logic [7:0]  jaddr_m;
   logic [31:0] exp_mon;
   int          cyc;
   int          strobe_cyc;
   int          n_pass;
   int          n_fail;
   int          n_total;

   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
      shadow[a] = d;
      if (!written[a]) begin
         written[a] = 1'b1;
         wq.push_back(a);
      end
   endfunction

   function automatic logic [7:0] pick_written();
      int unsigned k;
      k = $urandom_range(0, wq.size() - 1);
      return wq[k];
   endfunction

   // CPU write: wait for grant, then the RAM write must appear for one cycle
   task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input string tag);
      int w = 0;
      cpu_write = 1'b1; cpu_read = 1'b0; cpu_address = a; cpu_writedata = d;
      #1;
      while (cpu_waitrequest !== 1'b0 && w < 16) begin step(); #1; w++; end
      chkb({tag, " grant"}, w < 16, 1'b1);
      step();
      cpu_write = 1'b0;
      chkb({tag, " wren"}, ram_wren, 1'b1);
      chk8({tag, " addr"}, ram_addr, a);
      chk32({tag, " wdata"}, ram_wdata, d);
      m_write(a, d);
      step();
      chkb({tag, " wren drop"}, ram_wren, 1'b0);
   endtask

   // CPU read: data valid exactly three cycles after the grant
   task automatic cpu_rd(input logic [7:0] a, input logic both, input string tag);
      int w = 0;
      logic [31:0] e;
      cpu_read = 1'b1; cpu_write = both; cpu_address = a; cpu_writedata = $urandom;
      #1;
      while (cpu_waitrequest !== 1'b0 && w < 16) begin step(); #1; w++; end
      chkb({tag, " grant"}, w < 16, 1'b1);
      e = shadow[a];
      step();
      cpu_read = 1'b0; cpu_write = 1'b0;
      chkb({tag, " no wren"}, ram_wren, 1'b0);
      chk8({tag, " addr"}, ram_addr, a);
      chkb({tag, " rdv+1"}, cpu_readdatavalid, 1'b0);
      step();
      chkb({tag, " rdv+2"}, cpu_readdatavalid, 1'b0);
      step();
      chkb({tag, " rdv+3"}, cpu_readdatavalid, 1'b1);
      chk32({tag, " data"}, cpu_readdata, e);
      step();
      chkb({tag, " rdv+4"}, cpu_readdatavalid, 1'b0);
   endtask

   // One JTAG strobe; updates the model and returns one cycle later
   task automatic jtag_strobe(input logic sel_b, input logic rd, input logic [7:0] a,
                              input logic [31:0] d);
      jdo = '0;
      jdo[25:0] = 26'($urandom);
      if (sel_b) jdo[34:3] = d;
      else jdo[26 +: AW] = a;
      jdo[35] = rd;
      take_a = ~sel_b;
      take_b = sel_b;
      strobe_cyc = cyc;
      if (!sel_b) begin
         jaddr_m = a;
         if (rd) begin exp_mon = shadow[a]; jaddr_m++; end
      end else if (rd) begin
         exp_mon = shadow[jaddr_m]; jaddr_m++;
      end else begin
         m_write(jaddr_m, d); jaddr_m++;
      end
      step();
      take_a = 1'b0; take_b = 1'b0;
      chkb("jtag pending", jtag_busy, rd | sel_b);
   endtask

   task automatic jtag_settle(input string tag);
      while (cyc - strobe_cyc < 8) step();
      chkb({tag, " busy clear"}, jtag_busy, 1'b0);
      chk32({tag, " MonDReg"}, MonDReg, exp_mon);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; jdo = '0;
      cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
      n_pass = 0; n_fail = 0; n_total = 0; cyc = 0; strobe_cyc = -100;
      jaddr_m = '0; exp_mon = '0;

      // Reset state
      repeat (3) step();
      chkb("rst wren", ram_wren, 1'b0);
      chk8("rst addr", ram_addr, 8'h00);
      chk32("rst wdata", ram_wdata, 32'h0);
      chkb("rst rdv", cpu_readdatavalid, 1'b0);
      chk32("rst rdata", cpu_readdata, 32'h0);
      chk32("rst MonDReg", MonDReg, 32'h0);
      chkb("rst busy", jtag_busy, 1'b0);
      chk8("rst stall", stall_cnt, 8'h00);
      reset_n = 1'b1;
      step();
      chkb("idle waitreq", cpu_waitrequest, 1'b1);

      // Basic CPU write and read-back
      cpu_wr(8'h05, 32'hDEADBEEF, "cpu_wr5");
      cpu_rd(8'h05, 1'b0, "cpu_rd5");

      // Back-to-back CPU writes, one per cycle
      cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'hA5A50001;
      #1;
      chkb("b2b grant0", cpu_waitrequest, 1'b0);
      step();
      m_write(8'h20, 32'hA5A50001);
      cpu_address = 8'h21; cpu_writedata = 32'hA5A50002;
      #1;
      chkb("b2b grant1", cpu_waitrequest, 1'b0);
      chk8("b2b addr0", ram_addr, 8'h20);
      step();
      cpu_write = 1'b0;
      m_write(8'h21, 32'hA5A50002);
      chkb("b2b wren1", ram_wren, 1'b1);
      chk8("b2b addr1", ram_addr, 8'h21);
      step();

      // Read+write together is a read
      cpu_rd(8'h20, 1'b1, "cpu_rdwr");

      // JTAG address load, writes across the wrap point
      jtag_strobe(1'b0, 1'b0, 8'hFF, 32'h0);
      jtag_settle("ja_ff");
      jtag_strobe(1'b1, 1'b0, 8'h00, 32'h11111111);
      step();
      chkb("jw1 wren", ram_wren, 1'b1);
      chk8("jw1 addr", ram_addr, 8'hFF);
      chk32("jw1 wdata", ram_wdata, 32'h11111111);
      jtag_settle("jw1");
      jtag_strobe(1'b1, 1'b0, 8'h00, 32'h22222222);
      step();
      chk8("jw2 wrap addr", ram_addr, 8'h00);
      chk32("jw2 wdata", ram_wdata, 32'h22222222);
      jtag_settle("jw2");
      cpu_rd(8'hFF, 1'b0, "rd_ff");
      cpu_rd(8'h00, 1'b0, "rd_00");

      // JTAG read: MonDReg updates exactly four cycles after the strobe
      jtag_strobe(1'b0, 1'b1, 8'hFF, 32'h0);
      step();
      step();
      chk32("jr mon early", MonDReg, 32'h0);
      step();
      chk32("jr mon", MonDReg, 32'h11111111);
      jtag_settle("jr_ff");

      // Simultaneous strobes: only the address load happens
      jdo = '0;
      jdo[34:3] = 32'hCAFE0000;
      jdo[26 +: AW] = 8'h10;
      take_a = 1'b1; take_b = 1'b1;
      strobe_cyc = cyc;
      jaddr_m = 8'h10;
      step();
      take_a = 1'b0; take_b = 1'b0;
      chkb("both busy", jtag_busy, 1'b0);
      repeat (3) begin
         step();
         chkb("both no wren", ram_wren, 1'b0);
      end
      jtag_settle("both");
      jtag_strobe(1'b1, 1'b0, 8'h00, 32'h33333333);
      step();
      chk8("post-both addr", ram_addr, 8'h10);
      jtag_settle("post-both");

      // JTAG write pending while CPU write is held
      jtag_strobe(1'b1, 1'b0, 8'h00, 32'h44444444);
      cpu_write = 1'b1; cpu_address = 8'h30; cpu_writedata = 32'h55555555;
      #1;
      chkb("prio wait", cpu_waitrequest, 1'b1);
      step();
      chkb("prio jw wren", ram_wren, 1'b1);
      chk8("prio jw addr", ram_addr, 8'h11);
      chk32("prio jw data", ram_wdata, 32'h44444444);
      chkb("prio grant", cpu_waitrequest, 1'b0);
      chk8("prio stall", stall_cnt, STALL_EXP);
      step();
      cpu_write = 1'b0;
      m_write(8'h30, 32'h55555555);
      chkb("prio cw wren", ram_wren, 1'b1);
      chk8("prio cw addr", ram_addr, 8'h30);
      chk32("prio cw data", ram_wdata, 32'h55555555);
      chk8("prio stall hold", stall_cnt, STALL_EXP);
      jtag_settle("prio");

      // JTAG read strobe one cycle after a CPU read grant
      cpu_read = 1'b1; cpu_address = 8'h05;
      #1;
      chkb("cj grant", cpu_waitrequest, 1'b0);
      step();
      cpu_read = 1'b0;
      jtag_strobe(1'b0, 1'b1, 8'h30, 32'h0);
      step();
      chkb("cj rdv", cpu_readdatavalid, 1'b1);
      chk32("cj data", cpu_readdata, 32'hDEADBEEF);
      chkb("cj busy3", jtag_busy, 1'b1);
      step();
      chk8("cj jaddr", ram_addr, 8'h30);
      chkb("cj busy4", jtag_busy, 1'b1);
      chkb("cj rdv off", cpu_readdatavalid, 1'b0);
      step();
      chkb("cj busy5", jtag_busy, 1'b1);
      step();
      chkb("cj busy6", jtag_busy, 1'b0);
      chk32("cj mon", MonDReg, 32'h55555555);
      jtag_settle("cj");

      // Reset during a CPU read discards the read
      cpu_read = 1'b1; cpu_address = 8'h05;
      #1;
      chkb("rr grant", cpu_waitrequest, 1'b0);
      step();
      cpu_read = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      jaddr_m = '0; exp_mon = '0;
      chkb("rr rdv0", cpu_readdatavalid, 1'b0);
      chk8("rr addr", ram_addr, 8'h00);
      step();
      chkb("rr rdv1", cpu_readdatavalid, 1'b0);
      step();
      chkb("rr rdv2", cpu_readdatavalid, 1'b0);
      chk32("rr rdata", cpu_readdata, 32'h0);
      chk32("rr MonDReg", MonDReg, 32'h0);
      chkb("rr busy", jtag_busy, 1'b0);
      chk8("rr stall", stall_cnt, 8'h00);
      chkb("rr waitreq", cpu_waitrequest, 1'b1);
      jtag_strobe(1'b1, 1'b0, 8'h00, 32'h66666666);
      step();
      chk8("rr jaddr zero", ram_addr, 8'h00);
      jtag_settle("rr");

      // Randomized mix against the shadow model
      for (int i = 0; i < 150; i++) begin
         int unsigned op;
         op = $urandom_range(0, 3);
         if (op == 0) begin
            cpu_wr(8'($urandom), $urandom, "rnd_wr");
         end else if (op == 1) begin
            cpu_rd(pick_written(), 1'($urandom), "rnd_rd");
         end else begin
            logic sb;
            logic rd;
            sb = 1'($urandom);
            if (sb) begin
               rd = written[jaddr_m] ? 1'($urandom) : 1'b0;
               jtag_strobe(1'b1, rd, 8'h00, $urandom);
            end else begin
               rd = 1'($urandom);
               jtag_strobe(1'b0, rd, rd ? pick_written() : 8'($urandom), 32'h0);
            end
            if (op == 3) begin
               if ($urandom_range(0, 1) == 0) cpu_wr(8'($urandom), $urandom, "rnd_cwr");
               else cpu_rd(pick_written(), 1'b0, "rnd_crd");
            end
            jtag_settle("rnd_j");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
